rf_access_arbiter: RTL and testbench

- Sequences and shares the 32x32 dual-read register file between two requesters: a read client (two operand addresses) and a write-back client (one address plus data).
- The register file accepts only one of READ/WRITE per clock edge, and drives X if both or neither is asserted. This block guarantees mutually exclusive, correctly timed READ/WRITE pulses.
- It round-robins between the clients and returns captured read data with a valid pulse.

---
 rtl/rf_access_arbiter_if.sv | 37 +++
 rtl/rf_access_arbiter.sv | 66 ++++++
 tb/tb_rf_access_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_access_arbiter_if.sv
// rf_access_arbiter_if: client request/response and register-file bus bundle for rf_access_arbiter.
interface rf_access_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr1;
    logic [ADDR_WIDTH-1:0] rd_addr2;
    logic                  rd_gnt;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data1;
    logic [DATA_WIDTH-1:0] rd_data2;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_gnt;
    logic                  rf_read;
    logic                  rf_write;
    logic [ADDR_WIDTH-1:0] rf_addr_r1;
    logic [ADDR_WIDTH-1:0] rf_addr_r2;
    logic [ADDR_WIDTH-1:0] rf_addr_w;
    logic [DATA_WIDTH-1:0] rf_data_w;
    logic [DATA_WIDTH-1:0] rf_data_r1;
    logic [DATA_WIDTH-1:0] rf_data_r2;

    modport master (
        output rd_req, rd_addr1, rd_addr2, wr_req, wr_addr, wr_data, rf_data_r1, rf_data_r2,
        input  rd_gnt, rd_valid, rd_data1, rd_data2, wr_gnt,
        input  rf_read, rf_write, rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w
    );

    modport slave (
        input  rd_req, rd_addr1, rd_addr2, wr_req, wr_addr, wr_data, rf_data_r1, rf_data_r2,
        output rd_gnt, rd_valid, rd_data1, rd_data2, wr_gnt,
        output rf_read, rf_write, rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w
    );
endinterface

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter: round-robin sharing of a single-op-per-edge register file between a read and a write client.
module rf_access_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic              CLK,
    input  logic              RST,
    rf_access_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE} state_t;

    state_t state;
    logic   last_was_write;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            last_was_write <= 1'b1;
            bus.rd_gnt     <= 1'b0;
            bus.wr_gnt     <= 1'b0;
            bus.rd_valid   <= 1'b0;
            bus.rf_read    <= 1'b0;
            bus.rf_write   <= 1'b0;
            bus.rd_data1   <= '0;
            bus.rd_data2   <= '0;
            bus.rf_addr_r1 <= '0;
            bus.rf_addr_r2 <= '0;
            bus.rf_addr_w  <= '0;
            bus.rf_data_w  <= '0;
        end else begin
            bus.rd_gnt   <= 1'b0;
            bus.wr_gnt   <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rf_read  <= 1'b0;
            bus.rf_write <= 1'b0;
            case (state)
                IDLE: begin
                    // on a tie the read wins only if the previous grant went to the writer
                    if (bus.rd_req && (!bus.wr_req || last_was_write)) begin
                        state          <= RD_ISSUE;
                        bus.rf_addr_r1 <= bus.rd_addr1;
                        bus.rf_addr_r2 <= bus.rd_addr2;
                        bus.rd_gnt     <= 1'b1;
                        bus.rf_read    <= 1'b1;
                        last_was_write <= 1'b0;
                    end else if (bus.wr_req) begin
                        state          <= WR_ISSUE;
                        bus.rf_addr_w  <= bus.wr_addr;
                        bus.rf_data_w  <= bus.wr_data;
                        bus.wr_gnt     <= 1'b1;
                        bus.rf_write   <= |bus.wr_addr;
                        last_was_write <= 1'b1;
                    end
                end
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    state        <= IDLE;
                    bus.rd_data1 <= bus.rf_data_r1;
                    bus.rd_data2 <= bus.rf_data_r2;
                    bus.rd_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_access_arbiter.sv
// tb_rf_access_arbiter: scoreboard bench with a behavioural register file behind the arbiter.
module tb_rf_access_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_access_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    rf_access_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    // register file stand-in: registered read outputs, register 0 reads as zero
    logic [31:0] rf [32] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bus.rf_read) begin
            bus.rf_data_r1 <= rf[bus.rf_addr_r1];
            bus.rf_data_r2 <= rf[bus.rf_addr_r2];
        end
        if (bus.rf_write && bus.rf_addr_w != 5'd0) rf[bus.rf_addr_w] <= bus.rf_data_w;
    end

    typedef struct {
        int          kind;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        we;
    } ev_t;

    ev_t         q[$];
    logic [31:0] mdl [32] = '{default: 32'h0};
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_gnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ev_t ev(input int kind, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [4:0] a1, input logic [4:0] a2, input logic we);
        ev_t e;
        e.kind = kind; e.d1 = d1; e.d2 = d2; e.a1 = a1; e.a2 = a2; e.we = we;
        return e;
    endfunction

    initial forever begin
        @(negedge clk);
        cyc++;
        check("rf_excl", 32'(bus.rf_read & bus.rf_write), 32'h0);
        if (!rst && (bus.rd_gnt || bus.wr_gnt || bus.rd_valid)) begin
            if (q.size() == 0) begin
                check("unexpected_out", 32'({bus.rd_gnt, bus.wr_gnt, bus.rd_valid}), 32'h0);
            end else begin
                ev_t e;
                e = q.pop_front();
                check("event_kind", bus.rd_gnt ? 32'd0 : bus.wr_gnt ? 32'd1 : 32'd2, 32'(e.kind));
                if (e.kind == 0) begin
                    check("rd_rf_read", 32'(bus.rf_read), 32'h1);
                    check("rd_addr_r1", 32'(bus.rf_addr_r1), 32'(e.a1));
                    check("rd_addr_r2", 32'(bus.rf_addr_r2), 32'(e.a2));
                    last_gnt = cyc;
                end else if (e.kind == 1) begin
                    check("wr_rf_write", 32'(bus.rf_write), 32'(e.we));
                    check("wr_addr_w", 32'(bus.rf_addr_w), 32'(e.a1));
                    check("wr_data_w", bus.rf_data_w, e.d1);
                end else begin
                    check("rd_data1", bus.rd_data1, e.d1);
                    check("rd_data2", bus.rd_data2, e.d2);
                    check("rd_latency", 32'(cyc - last_gnt), 32'd2);
                end
            end
        end
    end

    task automatic wait_gnt(input bit is_rd);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!(is_rd ? bus.rd_gnt : bus.wr_gnt) && n < 30);
        if (!(is_rd ? bus.rd_gnt : bus.wr_gnt)) check("gnt_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (q.size() != 0) check("queue_drain", 32'(q.size()), 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        q.push_back(ev(1, d, 32'h0, a, 5'd0, a != 5'd0));
        bus.wr_addr = a; bus.wr_data = d; bus.wr_req = 1'b1;
        wait_gnt(1'b0);
        bus.wr_req = 1'b0;
        if (a != 5'd0) mdl[a] = d;
        wait_empty();
    endtask

    task automatic do_read(input logic [4:0] a1, input logic [4:0] a2);
        q.push_back(ev(0, 32'h0, 32'h0, a1, a2, 1'b0));
        q.push_back(ev(2, mdl[a1], mdl[a2], 5'd0, 5'd0, 1'b0));
        bus.rd_addr1 = a1; bus.rd_addr2 = a2; bus.rd_req = 1'b1;
        wait_gnt(1'b1);
        bus.rd_req = 1'b0;
        wait_empty();
    endtask

    initial begin
        int n;
        int g;
        bus.rd_req = 1'b1; bus.wr_req = 1'b1;
        bus.rd_addr1 = 5'd7; bus.rd_addr2 = 5'd3;
        bus.wr_addr = 5'd7; bus.wr_data = 32'hA5A5_0001;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_ctl", 32'({bus.rd_gnt, bus.wr_gnt, bus.rd_valid, bus.rf_read, bus.rf_write}), 32'h0);
            check("rst_rd_data", bus.rd_data1 | bus.rd_data2, 32'h0);
            check("rst_rf_bus", 32'({bus.rf_addr_r1, bus.rf_addr_r2, bus.rf_addr_w}) | bus.rf_data_w, 32'h0);
        end
        // contention: read first after reset, then strict alternation
        q.push_back(ev(0, 32'h0, 32'h0, 5'd7, 5'd3, 1'b0));
        q.push_back(ev(2, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0));
        q.push_back(ev(1, 32'hA5A5_0001, 32'h0, 5'd7, 5'd0, 1'b1));
        q.push_back(ev(0, 32'h0, 32'h0, 5'd7, 5'd3, 1'b0));
        q.push_back(ev(2, 32'hA5A5_0001, 32'h0, 5'd0, 5'd0, 1'b0));
        q.push_back(ev(1, 32'hA5A5_0001, 32'h0, 5'd7, 5'd0, 1'b1));
        rst = 1'b0;
        @(posedge clk); #1;
        check("first_gnt_is_rd", 32'(bus.rd_gnt), 32'h1);
        g = 1; n = 0;
        while (g < 4 && n < 40) begin
            @(posedge clk); #1; n++;
            if (bus.rd_gnt || bus.wr_gnt) g++;
        end
        bus.rd_req = 1'b0; bus.wr_req = 1'b0;
        check("contention_gnts", 32'(g), 32'd4);
        mdl[7] = 32'hA5A5_0001;
        wait_empty();

        do_write(5'd5, 32'hDEAD_BEEF);
        do_read(5'd5, 5'd0);
        do_write(5'd0, 32'h1);
        do_read(5'd0, 5'd5);
        do_write(5'd1, 32'h11);
        do_write(5'd2, 32'h22);
        do_write(5'd3, 32'h33);
        do_write(5'd4, 32'h44);

        // reset lands while the read sits in RD_WAIT
        q.push_back(ev(0, 32'h0, 32'h0, 5'd5, 5'd5, 1'b0));
        bus.rd_addr1 = 5'd5; bus.rd_addr2 = 5'd5; bus.rd_req = 1'b1;
        wait_gnt(1'b1);
        bus.rd_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ctl", 32'({bus.rd_valid, bus.rd_gnt, bus.rf_read, bus.rf_write}), 32'h0);
        check("midrst_data1", bus.rd_data1, 32'h0);
        check("midrst_data2", bus.rd_data2, 32'h0);
        rst = 1'b0;
        q.push_back(ev(0, 32'h0, 32'h0, 5'd1, 5'd2, 1'b0));
        q.push_back(ev(2, 32'h11, 32'h22, 5'd0, 5'd0, 1'b0));
        bus.rd_addr1 = 5'd1; bus.rd_addr2 = 5'd2; bus.rd_req = 1'b1;
        @(posedge clk); #1;
        check("gnt_after_rst", 32'(bus.rd_gnt), 32'h1);
        bus.rd_req = 1'b0;
        wait_empty();

        // back-to-back reads with the address pair swapped after the first grant
        q.push_back(ev(0, 32'h0, 32'h0, 5'd1, 5'd2, 1'b0));
        q.push_back(ev(2, 32'h11, 32'h22, 5'd0, 5'd0, 1'b0));
        q.push_back(ev(0, 32'h0, 32'h0, 5'd3, 5'd4, 1'b0));
        q.push_back(ev(2, 32'h33, 32'h44, 5'd0, 5'd0, 1'b0));
        bus.rd_addr1 = 5'd1; bus.rd_addr2 = 5'd2; bus.rd_req = 1'b1;
        wait_gnt(1'b1);
        bus.rd_addr1 = 5'd3; bus.rd_addr2 = 5'd4;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!bus.rd_gnt && n < 10);
        bus.rd_req = 1'b0;
        check("b2b_gap", 32'(n), 32'd3);
        wait_empty();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
